// File: rtl/ga_run_ctrl_if.sv
// Signal bundle between ga_run_ctrl (master) and the host / GA datapath (slave).
// GA_RUN_CTRL_ABORT_EN adds the abort input.
interface ga_run_ctrl_if #(
  parameter int CHROM_W  = 8,
  parameter int FIT_W    = 27,
  parameter int ROUNDS_W = 16
);
  // host control
  logic                       start;
  logic [31:0]                seed_in;
  logic [ROUNDS_W-1:0]        num_rounds;
`ifdef GA_RUN_CTRL_ABORT_EN
  logic                       abort;
`endif
  // rng8 / fitness_function / selection side
  logic [31:0]                rng_seed;
  logic                       rng_reset;
  logic signed [CHROM_W-1:0]  chrom1_in;
  logic signed [CHROM_W-1:0]  chrom2_in;
  logic signed [FIT_W-1:0]    fitness1_in;
  logic signed [FIT_W-1:0]    fitness2_in;
  logic                       selected_in;
  // results
  logic                       winner_valid;
  logic signed [CHROM_W-1:0]  winner_chrom;
  logic signed [FIT_W-1:0]    winner_fitness;
  logic                       best_valid;
  logic signed [CHROM_W-1:0]  best_chrom;
  logic signed [FIT_W-1:0]    best_fitness;
  logic [ROUNDS_W-1:0]        round_count;
  logic                       busy;
  logic                       done;

  modport master (
`ifdef GA_RUN_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, seed_in, num_rounds,
    input  chrom1_in, chrom2_in, fitness1_in, fitness2_in, selected_in,
    output rng_seed, rng_reset,
    output winner_valid, winner_chrom, winner_fitness,
    output best_valid, best_chrom, best_fitness,
    output round_count, busy, done
  );

  modport slave (
`ifdef GA_RUN_CTRL_ABORT_EN
    output abort,
`endif
    output start, seed_in, num_rounds,
    output chrom1_in, chrom2_in, fitness1_in, fitness2_in, selected_in,
    input  rng_seed, rng_reset,
    input  winner_valid, winner_chrom, winner_fitness,
    input  best_valid, best_chrom, best_fitness,
    input  round_count, busy, done
  );
endinterface

// File: rtl/ga_run_ctrl.sv
// GA tournament run controller: seeds rng8, issues N pairs, aligns fitness and
// selection, emits round winners and tracks the run's best. Option: GA_RUN_CTRL_ABORT_EN.
module ga_run_ctrl #(
  parameter int CHROM_W  = 8,
  parameter int FIT_W    = 27,
  parameter int ROUNDS_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  ga_run_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEED, WAIT, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [31:0]                seed_q;
  logic [ROUNDS_W-1:0]        rounds_q;
  logic [ROUNDS_W-1:0]        issue_cnt;
  logic [1:0]                 drain_cnt;
  logic                       accept;
  logic                       issue;
  logic                       flush;

  logic                       s1_vld, s2_vld;
  logic signed [CHROM_W-1:0]  s1_c1, s1_c2, s2_c1, s2_c2;
  logic signed [FIT_W-1:0]    s2_f1, s2_f2;

  logic                       win_vld;
  logic signed [CHROM_W-1:0]  win_chrom;
  logic signed [FIT_W-1:0]    win_fit;
  logic                       best_vld;
  logic signed [CHROM_W-1:0]  best_chrom;
  logic signed [FIT_W-1:0]    best_fit;
  logic [ROUNDS_W-1:0]        rnd_cnt;

  assign accept = (state == IDLE) && bus.start;
  assign issue  = (state == RUN);

`ifdef GA_RUN_CTRL_ABORT_EN
  assign flush = bus.abort && (state != IDLE);
`else
  assign flush = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.num_rounds == '0) ? DONE : SEED;
      SEED:    state_nxt = WAIT;
      WAIT:    state_nxt = RUN;
      RUN:     if (issue_cnt == rounds_q - ROUNDS_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      seed_q    <= '0;
      rounds_q  <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (accept) begin
        seed_q    <= bus.seed_in;
        rounds_q  <= bus.num_rounds;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + ROUNDS_W'(1);
      end
    end
  end

  // Pair issued at t, fitness arrives at t+1, verdict at t+2, winner visible at t+3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      win_vld   <= 1'b0;
      s1_c1     <= '0;
      s1_c2     <= '0;
      s2_c1     <= '0;
      s2_c2     <= '0;
      s2_f1     <= '0;
      s2_f2     <= '0;
      win_chrom <= '0;
      win_fit   <= '0;
    end else begin
      s1_vld  <= issue && !flush;
      s2_vld  <= s1_vld && !flush;
      win_vld <= s2_vld && !flush;
      if (issue) begin
        s1_c1 <= bus.chrom1_in;
        s1_c2 <= bus.chrom2_in;
      end
      if (s1_vld) begin
        s2_c1 <= s1_c1;
        s2_c2 <= s1_c2;
        s2_f1 <= bus.fitness1_in;
        s2_f2 <= bus.fitness2_in;
      end
      if (s2_vld) begin
        win_chrom <= bus.selected_in ? s2_c1 : s2_c2;
        win_fit   <= bus.selected_in ? s2_f1 : s2_f2;
      end
    end
  end

  // Strict signed compare: a tie keeps the earlier best.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rnd_cnt    <= '0;
      best_vld   <= 1'b0;
      best_chrom <= '0;
      best_fit   <= '0;
    end else if (accept) begin
      rnd_cnt    <= '0;
      best_vld   <= 1'b0;
      best_chrom <= '0;
      best_fit   <= '0;
    end else if (win_vld) begin
      if (rnd_cnt != '1) rnd_cnt <= rnd_cnt + ROUNDS_W'(1);
      if (!best_vld || (win_fit > best_fit)) begin
        best_chrom <= win_chrom;
        best_fit   <= win_fit;
      end
      best_vld <= 1'b1;
    end
  end

  assign bus.rng_seed       = seed_q;
  assign bus.rng_reset      = (state == SEED);
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.winner_valid   = win_vld;
  assign bus.winner_chrom   = win_chrom;
  assign bus.winner_fitness = win_fit;
  assign bus.best_valid     = best_vld;
  assign bus.best_chrom     = best_chrom;
  assign bus.best_fitness   = best_fit;
  assign bus.round_count    = rnd_cnt;

endmodule
